// File: rtl/ii_pkg.sv
// Shared integral-image geometry, widths and the bank-arbiter state type.
// Used by the II capture path and the face-detector sequencer.
package ii_pkg;
  localparam int II_WIDTH    = 160;
  localparam int II_HEIGHT   = 120;
  localparam int FRAME_WORDS = II_WIDTH * II_HEIGHT;
  localparam int II_DATA_W   = 20;
  localparam int II_ADDR_W   = 15;

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    CHECK,
    SWAP
  } ii_arb_state_t;
endpackage

// File: rtl/ii_vsync_edge.sv
// Registers camera vsync once and derives start-of-frame (fall) and
// end-of-frame (rise) pulses, combinational from the registered copy.
module ii_vsync_edge
  import ii_pkg::*;
(
  input  logic ov7670_pclk,
  input  logic rst,
  input  logic vsync,
  output logic sof,
  output logic eof
);
  logic vsync_q, vsync_d;

  always_comb begin
    vsync_d = vsync;
    sof     = vsync_q & ~vsync;
    eof     = ~vsync_q & vsync;
  end

  // Reset low: a vsync already high at release only yields an eof, which WAIT_SOF ignores.
  always_ff @(posedge ov7670_pclk) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync_d;
  end
endmodule

// File: rtl/ii_bank_arbiter.sv
// Ping-pong arbiter for the 2-bank integral-image RAM: the writer fills one bank
// while the reader owns the other; banks swap only on a complete, released frame.
module ii_bank_arbiter
  import ii_pkg::*;
#(
  parameter int ADDR_W      = II_ADDR_W,
  parameter int DATA_W      = II_DATA_W,
  parameter int FRAME_WORDS = ii_pkg::FRAME_WORDS
) (
  input  logic              ov7670_pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W:0]   ram_raddr,
  output logic              frame_avail,
  output logic              frame_dropped,
  output logic              frame_err,
  output logic [7:0]        drop_count
);
  localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  ii_arb_state_t     state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              miss_eof_q, miss_eof_d;
  logic              resume_q, resume_d;
  logic              frame_avail_q, frame_avail_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_dropped_q, frame_dropped_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W:0]   ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              sof, eof;
  logic              drop_inc;
  logic              go_fill;

  ii_vsync_edge u_vsync_edge (
    .ov7670_pclk (ov7670_pclk),
    .rst         (rst),
    .vsync       (vsync),
    .sof         (sof),
    .eof         (eof)
  );

  always_comb begin
    state_d         = state_q;
    wr_bank_d       = wr_bank_q;
    count_d         = count_q;
    miss_eof_d      = miss_eof_q;
    resume_d        = resume_q;
    // A release takes effect before any CHECK decision in the same cycle.
    frame_avail_d   = frame_avail_q & ~rd_done;
    frame_err_d     = 1'b0;
    frame_dropped_d = 1'b0;
    drop_inc        = 1'b0;
    // A start-of-frame seen during CHECK/SWAP (short vsync gap) is not lost.
    go_fill         = resume_q | sof;

    case (state_q)
      WAIT_SOF: begin
        if (sof) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      FILL: begin
        if (wr_en && count_q != CNT_MAX) count_d = count_q + 1'b1;
        if (sof) begin
          state_d    = CHECK;
          miss_eof_d = 1'b1;
          resume_d   = 1'b1;
        end else if (eof) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        miss_eof_d = 1'b0;
        if (miss_eof_q || count_q != FW_A) begin
          frame_err_d = 1'b1;
          drop_inc    = 1'b1;
        end else if (frame_avail_d) begin
          frame_dropped_d = 1'b1;
          drop_inc        = 1'b1;
        end
        if (!drop_inc) begin
          state_d  = SWAP;
          resume_d = go_fill;
        end else if (go_fill) begin
          state_d  = FILL;
          count_d  = '0;
          resume_d = 1'b0;
        end else begin
          state_d = WAIT_SOF;
        end
      end
      SWAP: begin
        wr_bank_d     = ~wr_bank_q;
        frame_avail_d = 1'b1;
        if (go_fill) begin
          state_d  = FILL;
          count_d  = '0;
          resume_d = 1'b0;
        end else begin
          state_d = WAIT_SOF;
        end
      end
      default: state_d = WAIT_SOF;
    endcase

    drop_count_d = (drop_inc && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;

    // Out-of-range words were already counted above; only the RAM write is blocked.
    ram_we_d    = wr_en && (state_q == FILL) && (wr_addr < FW_A);
    ram_waddr_d = {wr_bank_q, wr_addr};
    ram_wdata_d = wr_data;
  end

  always_ff @(posedge ov7670_pclk) begin
    if (rst) begin
      state_q         <= WAIT_SOF;
      wr_bank_q       <= 1'b0;
      count_q         <= '0;
      miss_eof_q      <= 1'b0;
      resume_q        <= 1'b0;
      frame_avail_q   <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_dropped_q <= 1'b0;
      drop_count_q    <= '0;
      ram_we_q        <= 1'b0;
      ram_waddr_q     <= '0;
      ram_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      wr_bank_q       <= wr_bank_d;
      count_q         <= count_d;
      miss_eof_q      <= miss_eof_d;
      resume_q        <= resume_d;
      frame_avail_q   <= frame_avail_d;
      frame_err_q     <= frame_err_d;
      frame_dropped_q <= frame_dropped_d;
      drop_count_q    <= drop_count_d;
      ram_we_q        <= ram_we_d;
      ram_waddr_q     <= ram_waddr_d;
      ram_wdata_q     <= ram_wdata_d;
    end
  end

  assign ram_we        = ram_we_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_re        = rd_en & frame_avail_q;
  assign ram_raddr     = {~wr_bank_q, rd_addr};
  assign frame_avail   = frame_avail_q;
  assign frame_err     = frame_err_q;
  assign frame_dropped = frame_dropped_q;
  assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_ii_bank_arbiter.sv
// Directed bench for ii_bank_arbiter: vector tables for the write/read paths,
// hand sequences for frame outcomes, short vsync gaps, saturation and reset.
module tb_ii_bank_arbiter;
  localparam int AW = 15;
  localparam int DW = 20;
  localparam int FW = 300;

  logic          ov7670_pclk = 1'b0;
  logic          rst, vsync, wr_en, rd_en, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          ram_we, ram_re, frame_avail, frame_dropped, frame_err;
  logic [AW:0]   ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [7:0]    drop_count;
  int            n_cmp = 0;
  int            n_fail = 0;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_we;
  } wr_vec_t;

  typedef struct {
    logic          after_swap;
    logic          en;
    logic [AW-1:0] addr;
    logic          exp_re;
    logic [AW:0]   exp_raddr;
  } rd_vec_t;

  wr_vec_t wr_tab[6];
  rd_vec_t rd_tab[6];

  always #5 ov7670_pclk = ~ov7670_pclk;

  ii_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
    .ov7670_pclk   (ov7670_pclk),
    .rst           (rst),
    .vsync         (vsync),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_done       (rd_done),
    .ram_we        (ram_we),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .ram_re        (ram_re),
    .ram_raddr     (ram_raddr),
    .frame_avail   (frame_avail),
    .frame_dropped (frame_dropped),
    .frame_err     (frame_err),
    .drop_count    (drop_count)
  );

  task automatic step();
    @(posedge ov7670_pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    step();
  endtask

  task automatic write_words(input int n, input int oob_at);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = (i == oob_at) ? 15'(FW) : 15'(i);
      wr_data = 20'(i * 3 + 1);
      step();
      if (i == oob_at) chk("oob_we", 32'(ram_we), 32'd0);
      if (i == oob_at + 1) chk("after_oob_we", 32'(ram_we), 32'd1);
    end
    wr_en = 1'b0;
  endtask

  task automatic rel_pulse();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic done_in_check,
                           input logic e_err, input logic e_drp, input logic e_av1,
                           input logic e_av2, input logic e_rbank, input logic [7:0] e_dc);
    vsync = 1'b1;
    step();
    rd_done = done_in_check;
    step();
    rd_done = 1'b0;
    chk({tag, "_err"},  32'(frame_err), 32'(e_err));
    chk({tag, "_drop"}, 32'(frame_dropped), 32'(e_drp));
    chk({tag, "_dc"},   32'(drop_count), 32'(e_dc));
    chk({tag, "_av1"},  32'(frame_avail), 32'(e_av1));
    step();
    chk({tag, "_av2"},   32'(frame_avail), 32'(e_av2));
    chk({tag, "_pulse"}, 32'(frame_err | frame_dropped), 32'd0);
    chk({tag, "_rbank"}, 32'(ram_raddr[AW]), 32'(e_rbank));
  endtask

  task automatic run_rd_tab(input logic phase);
    for (int i = 0; i < 6; i++) begin
      if (rd_tab[i].after_swap == phase) begin
        rd_en   = rd_tab[i].en;
        rd_addr = rd_tab[i].addr;
        #1;
        chk($sformatf("rd%0d_re", i), 32'(ram_re), 32'(rd_tab[i].exp_re));
        chk($sformatf("rd%0d_raddr", i), 32'(ram_raddr), 32'(rd_tab[i].exp_raddr));
      end
    end
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; wr_en = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    wr_tab[0] = '{1'b1, 15'd0,      20'h00011, 1'b1};
    wr_tab[1] = '{1'b0, 15'd1,      20'h00022, 1'b0};
    wr_tab[2] = '{1'b1, 15'(FW-1),  20'hABCDE, 1'b1};
    wr_tab[3] = '{1'b1, 15'(FW),    20'h00033, 1'b0};
    wr_tab[4] = '{1'b1, 15'h7FFF,   20'h00044, 1'b0};
    wr_tab[5] = '{1'b1, 15'd2,      20'hFFFFF, 1'b1};

    // Before any swap wr_bank=0, so the reader side addresses bank 1.
    rd_tab[0] = '{1'b0, 1'b1, 15'd5,    1'b0, 16'h8005};
    rd_tab[1] = '{1'b0, 1'b0, 15'h7FFF, 1'b0, 16'hFFFF};
    rd_tab[2] = '{1'b0, 1'b1, 15'd0,    1'b0, 16'h8000};
    // After the first swap wr_bank=1: the reader owns bank 0, where that frame was written.
    rd_tab[3] = '{1'b1, 1'b1, 15'd5,    1'b1, 16'h0005};
    rd_tab[4] = '{1'b1, 1'b0, 15'd9,    1'b0, 16'h0009};
    rd_tab[5] = '{1'b1, 1'b1, 15'h7FFF, 1'b1, 16'h7FFF};

    repeat (3) step();
    chk("rst_we",    32'(ram_we), 32'd0);
    chk("rst_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_avail", 32'(frame_avail), 32'd0);
    chk("rst_err",   32'(frame_err), 32'd0);
    chk("rst_drop",  32'(frame_dropped), 32'd0);
    chk("rst_dc",    32'(drop_count), 32'd0);
    chk("rst_re",    32'(ram_re), 32'd0);
    chk("rst_raddr", 32'(ram_raddr), 32'h8000);
    rst = 1'b0;

    wr_en = 1'b1; wr_addr = 15'd3; wr_data = 20'h5;
    step();
    wr_en = 1'b0;
    chk("pre_sof_we",    32'(ram_we), 32'd0);
    chk("pre_sof_waddr", 32'(ram_waddr), 32'h0003);
    run_rd_tab(1'b0);

    // T1: full frame into bank 0, including in-range edge and out-of-range words
    start_frame();
    for (int i = 0; i < 6; i++) begin
      wr_en = wr_tab[i].en; wr_addr = wr_tab[i].addr; wr_data = wr_tab[i].data;
      step();
      chk($sformatf("wr%0d_we", i),    32'(ram_we), 32'(wr_tab[i].exp_we));
      chk($sformatf("wr%0d_waddr", i), 32'(ram_waddr), 32'({1'b0, wr_tab[i].addr}));
      chk($sformatf("wr%0d_wdata", i), 32'(ram_wdata), 32'(wr_tab[i].data));
    end
    wr_en = 1'b0;
    write_words(FW - 5, -1);
    check_end("t1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step();
    chk("t1_wbank", 32'(ram_waddr[AW]), 32'd1);
    run_rd_tab(1'b1);

    // T2: reader still holds its bank
    start_frame();
    write_words(FW, -1);
    check_end("t2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);

    rel_pulse();
    chk("rel_avail", 32'(frame_avail), 32'd0);
    rel_pulse();
    chk("idle_rel_avail", 32'(frame_avail), 32'd0);

    // T3: short frame
    start_frame();
    write_words(FW - 1, -1);
    check_end("t3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    // T4: word at address FW is blocked from RAM but still counted
    start_frame();
    write_words(FW, 10);
    check_end("t4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);

    // T5: release arrives in the CHECK cycle
    start_frame();
    write_words(FW, -1);
    check_end("t5", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);

    // T6: one-cycle vsync gap; the following frame must still be captured
    rel_pulse();
    chk("t6_rel", 32'(frame_avail), 32'd0);
    start_frame();
    write_words(FW, -1);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    chk("t6_err",  32'(frame_err), 32'd0);
    chk("t6_drop", 32'(frame_dropped), 32'd0);
    step();
    chk("t6_avail", 32'(frame_avail), 32'd1);
    chk("t6_rbank", 32'(ram_raddr[AW]), 32'd1);
    write_words(FW, -1);
    check_end("t6b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3);

    // T7: empty frames drive drop_count into saturation
    for (int i = 0; i < 260; i++) begin
      start_frame();
      vsync = 1'b1;
      step();
      step();
      if (i == 250) chk("sat_254", 32'(drop_count), 32'd254);
      if (i == 251) chk("sat_255", 32'(drop_count), 32'd255);
      if (i == 259) begin
        chk("sat_hold", 32'(drop_count), 32'd255);
        chk("sat_err",  32'(frame_err), 32'd1);
      end
    end

    // T8: reset in the middle of FILL
    start_frame();
    write_words(100, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t8_avail", 32'(frame_avail), 32'd0);
    chk("t8_dc",    32'(drop_count), 32'd0);
    chk("t8_rbank", 32'(ram_raddr[AW]), 32'd1);
    start_frame();
    write_words(FW, -1);
    check_end("t8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
